// File: rtl/arb_memory_controller.sv
// arb_memory_controller
//   Round-robin arbiter in front of a MEM_DEPTH-word register-file memory with
//   a programmable grant-to-ack latency. Accesses are serialised: one access
//   in flight at a time, operands latched at grant.
//
//   Handshake: a channel raises req[i] with we/addr/data stable and holds it
//   until it sees ack[i] high for one cycle, then drops req in that cycle. A req
//   still high at the next IDLE edge is a new request. value/error/resp_ch
//   are valid while any ack bit is high; value holds its last result after.
//
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     req, we         per-channel request / write enable (NUM_CH bits)
//     addr, data      flattened per-channel address / write data
//     ack             one-hot, single-cycle completion strobe
//     value           read data (0 for writes and out-of-range accesses)
//     resp_ch         index of the channel being acked
//     error           out-of-range flag (addr >= MEM_DEPTH)
//     busy            high whenever the FSM is not IDLE
//
//   Optional feature macro: ARB_MEM_CTRL_STATS_EN adds access_count (16-bit,
//   wrapping) and error_count (8-bit, saturating) outputs.
module arb_memory_controller #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int MEM_DEPTH  = 5,
    parameter int LATENCY    = 2,
    parameter int NUM_CH     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            req,
    input  logic [NUM_CH-1:0]            we,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data,
    output logic [NUM_CH-1:0]            ack,
    output logic [DATA_WIDTH-1:0]        value,
    output logic [$clog2(NUM_CH)-1:0]    resp_ch,
    output logic                         error,
    output logic                         busy
`ifdef ARB_MEM_CTRL_STATS_EN
    ,
    output logic [15:0]                  access_count,
    output logic [7:0]                   error_count
`endif
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [CNT_W-1:0]    CNT_LOAD  = CNT_W'(LATENCY - 1);
    localparam logic [CH_W-1:0]     LAST_CH   = CH_W'(NUM_CH - 1);
    localparam logic [CH_W:0]       NCH_W     = (CH_W + 1)'(NUM_CH);
    localparam logic [ADDR_WIDTH:0] DEPTH_CMP = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state, state_next;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [CH_W-1:0]       ptr;
    logic [CNT_W-1:0]      cnt;
    logic [CH_W-1:0]       lat_ch;
    logic                  lat_we;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_data;

    logic                  grant_found;
    logic [CH_W-1:0]       grant_idx;
    logic [CH_W:0]         scan_idx;
    logic                  do_grant;
    logic                  do_access;
    logic                  in_range;
    logic [IDX_W-1:0]      mem_idx;

    // Compare with one extra bit so MEM_DEPTH == 2**ADDR_WIDTH makes every
    // address in range.
    assign in_range = ({1'b0, lat_addr} < DEPTH_CMP);
    assign mem_idx  = lat_addr[IDX_W-1:0];
    assign busy     = (state != IDLE);

    // Round-robin scan: walk downward so the lowest offset from ptr wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            scan_idx = {1'b0, ptr} + (CH_W + 1)'(k);
            if (scan_idx >= NCH_W) begin
                scan_idx = scan_idx - NCH_W;
            end
            if (req[scan_idx[CH_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[CH_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        do_grant   = 1'b0;
        do_access  = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    do_grant   = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    do_access  = 1'b1;
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            cnt      <= '0;
            lat_ch   <= '0;
            lat_we   <= 1'b0;
            lat_addr <= '0;
            lat_data <= '0;
            ack      <= '0;
            value    <= '0;
            resp_ch  <= '0;
            error    <= 1'b0;
        end else begin
            if (do_grant) begin
                lat_ch   <= grant_idx;
                lat_we   <= we[grant_idx];
                lat_addr <= addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                lat_data <= data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                cnt      <= CNT_LOAD;
                ptr      <= (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
            end
            if (state == ACCESS && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (do_access) begin
                ack         <= '0;
                ack[lat_ch] <= 1'b1;
                resp_ch     <= lat_ch;
                if (!in_range) begin
                    value <= '0;
                    error <= 1'b1;
                end else begin
                    error <= 1'b0;
                    value <= lat_we ? '0 : mem[mem_idx];
                end
            end
            if (state == RESP) begin
                ack   <= '0;
                error <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_access && lat_we && in_range) begin
            mem[mem_idx] <= lat_data;
        end
    end

`ifdef ARB_MEM_CTRL_STATS_EN
    // Counted at the edge that raises ack, so the counters move with ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            access_count <= '0;
            error_count  <= '0;
        end else if (do_access) begin
            access_count <= access_count + 16'd1;
            if (!in_range && error_count != 8'hFF) begin
                error_count <= error_count + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_arb_memory_controller.sv
// Self-checking bench for arb_memory_controller (default parameters).
// A transaction-level model predicts ack/value/resp_ch/error/busy from
// edge arithmetic (grant edge N -> ack after edge N+LATENCY, idle again after
// N+LATENCY+1) and a plain array memory; a negedge process compares every
// cycle and a scoreboard queue matches each ack to its predicted result.
module tb_arb_memory_controller;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int DEPTH = 5;
  localparam int LAT = 2;
  localparam int NCH = 2;
  localparam int CHW = $clog2(NCH);
  localparam int SW = CHW + 1 + DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NCH-1:0] req = '0;
  logic [NCH-1:0] we = '0;
  logic [NCH*AW-1:0] addr = '0;
  logic [NCH*DW-1:0] data = '0;
  logic [NCH-1:0] ack;
  logic [DW-1:0] value;
  logic [CHW-1:0] resp_ch;
  logic error;
  logic busy;
`ifdef ARB_MEM_CTRL_STATS_EN
  logic [15:0] access_count;
  logic [7:0] error_count;
`endif

  arb_memory_controller #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .LATENCY(LAT), .NUM_CH(NCH)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .data(data),
    .ack(ack), .value(value), .resp_ch(resp_ch), .error(error), .busy(busy)
`ifdef ARB_MEM_CTRL_STATS_EN
    , .access_count(access_count), .error_count(error_count)
`endif
  );

  // clock/reset block
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  int e = 0;

  // model state
  logic [DW-1:0] m_mem [DEPTH];
  int m_ptr = 0;
  bit m_inflight = 1'b0;
  int m_g = 0;
  bit m_we = 1'b0;
  int m_addr = 0;
  logic [DW-1:0] m_data = '0;
  int m_acc_edge = 0;
  logic [NCH-1:0] exp_ack = '0;
  logic [DW-1:0] exp_value = '0;
  int exp_resp_ch = 0;
  bit exp_error = 1'b0;
  bit exp_busy = 1'b0;
  int exp_acc_cnt = 0;
  int exp_err_cnt = 0;
  logic [SW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model on the same edge the DUT samples, then
  // apply the requester rule (drop req in the cycle its ack is seen).
  task automatic step();
    bit idle_before;
    bit found;
    int c;
    @(posedge clk);
    e++;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_ptr = 0;
      m_inflight = 1'b0;
      exp_ack = '0;
      exp_value = '0;
      exp_resp_ch = 0;
      exp_error = 1'b0;
      exp_acc_cnt = 0;
      exp_err_cnt = 0;
      exp_q.delete();
    end else begin
      idle_before = !m_inflight;
      if (m_inflight && e == m_acc_edge) begin
        if (m_addr < DEPTH) begin
          if (m_we) begin
            m_mem[m_addr] = m_data;
            exp_value = '0;
          end else begin
            exp_value = m_mem[m_addr];
          end
          exp_error = 1'b0;
        end else begin
          exp_value = '0;
          exp_error = 1'b1;
        end
        exp_ack = '0;
        exp_ack[m_g] = 1'b1;
        exp_resp_ch = m_g;
        exp_acc_cnt = (exp_acc_cnt + 1) % 65536;
        if (exp_error && exp_err_cnt < 255) exp_err_cnt++;
        exp_q.push_back({CHW'(m_g), exp_error, exp_value});
      end else if (m_inflight && e == m_acc_edge + 1) begin
        exp_ack = '0;
        exp_error = 1'b0;
        m_inflight = 1'b0;
      end
      if (idle_before && req != '0) begin
        found = 1'b0;
        c = 0;
        for (int k = 0; k < NCH; k++) begin
          int cc;
          cc = (m_ptr + k) % NCH;
          if (!found && req[cc]) begin
            found = 1'b1;
            c = cc;
          end
        end
        m_g = c;
        m_we = we[c];
        m_addr = int'(addr[c*AW +: AW]);
        m_data = data[c*DW +: DW];
        m_acc_edge = e + LAT;
        m_inflight = 1'b1;
        m_ptr = (c + 1) % NCH;
      end
    end
    exp_busy = m_inflight;
    #1;
    req = req & ~exp_ack;
  endtask

  // compare process
  always @(negedge clk) begin
    if (chk_en) begin
      logic [SW-1:0] ent;
      check("ack", 32'(ack), 32'(exp_ack));
      check("value", 32'(value), 32'(exp_value));
      check("resp_ch", 32'(resp_ch), 32'(exp_resp_ch));
      check("error", 32'(error), 32'(exp_error));
      check("busy", 32'(busy), 32'(exp_busy));
`ifdef ARB_MEM_CTRL_STATS_EN
      check("access_count", 32'(access_count), 32'(exp_acc_cnt));
      check("error_count", 32'(error_count), 32'(exp_err_cnt));
`endif
      if (ack != '0) begin
        check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          ent = exp_q.pop_front();
          check("sb_result", 32'({resp_ch, error, value}), 32'(ent));
        end
      end
    end
  end

  // driver: issue one access on a channel and wait (bounded) for its ack
  task automatic run_acc(input int ch, input bit w, input int a, input logic [DW-1:0] d,
                         output logic [DW-1:0] v, output logic er, output int rc, output int lat);
    req[ch] = 1'b1;
    we[ch] = w;
    addr[ch*AW +: AW] = AW'(a);
    data[ch*DW +: DW] = d;
    lat = -1;
    v = 'x;
    er = 1'bx;
    rc = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (ack[ch] === 1'b1) begin
        lat = i;
        v = value;
        er = error;
        rc = int'(resp_ch);
        break;
      end
    end
    if (lat < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL ack_timeout: ch%0d got no ack within 40 cycles", ch);
    end
    req[ch] = 1'b0;
    step();
  endtask

  // two channels request together; returns ack order
  task automatic run_pair(input int a, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                          output int first, output int second);
    int n;
    int ord[2];
    ord[0] = -1;
    ord[1] = -1;
    n = 0;
    req = '1;
    we = '1;
    addr[0 +: AW] = AW'(a);
    addr[AW +: AW] = AW'(a);
    data[0 +: DW] = d0;
    data[DW +: DW] = d1;
    for (int i = 0; i < 40 && n < 2; i++) begin
      step();
      if (ack[0] === 1'b1) begin ord[n] = 0; n++; end
      else if (ack[1] === 1'b1) begin ord[n] = 1; n++; end
    end
    req = '0;
    step();
    first = ord[0];
    second = ord[1];
  endtask

  initial begin
    logic [DW-1:0] v;
    logic er;
    int rc, lat, f, s;

    // reset then idle
    rst = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_value", 32'(value), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    run_acc(0, 1'b0, 3, 16'h0, v, er, rc, lat);
    check("rd3_after_rst", 32'(v), 32'h0000);

    // write/read latency
    run_acc(0, 1'b1, 1, 16'hBEEF, v, er, rc, lat);
    check("wr1_latency", lat, 32'(LAT + 1));
    check("wr1_error", 32'(er), 32'd0);
    check("wr1_value", 32'(v), 32'd0);
    run_acc(0, 1'b0, 1, 16'h0, v, er, rc, lat);
    check("rd1_value", 32'(v), 32'hBEEF);
    check("rd1_latency", lat, 32'(LAT + 1));
    check("rd1_resp_ch", rc, 32'd0);

    // out-of-range on ch1
    run_acc(1, 1'b0, 6, 16'h0, v, er, rc, lat);
    check("oor_rd6_error", 32'(er), 32'd1);
    check("oor_rd6_value", 32'(v), 32'd0);
    check("oor_rd6_resp_ch", rc, 32'd1);
    run_acc(1, 1'b1, 5, 16'h1234, v, er, rc, lat);
    check("oor_wr5_error", 32'(er), 32'd1);
    check("oor_wr5_value", 32'(v), 32'd0);
    run_acc(1, 1'b0, 15, 16'h0, v, er, rc, lat);
    check("oor_rd15_error", 32'(er), 32'd1);
    for (int a = 0; a < DEPTH; a++) begin
      run_acc(0, 1'b0, a, 16'h0, v, er, rc, lat);
      check($sformatf("no_corrupt_addr%0d", a), 32'(v), (a == 1) ? 32'hBEEF : 32'h0);
    end

    // simultaneous requests from reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    run_pair(0, 16'h1111, 16'h2222, f, s);
    check("pair1_first", f, 32'd0);
    check("pair1_second", s, 32'd1);
    run_acc(0, 1'b0, 0, 16'h0, v, er, rc, lat);
    check("pair1_last_write_wins", 32'(v), 32'h2222);
    run_pair(4, 16'h3333, 16'h4444, f, s);
    check("pair2_first", f, 32'd1);
    check("pair2_second", s, 32'd0);
    run_acc(1, 1'b0, 4, 16'h0, v, er, rc, lat);
    check("pair2_last_write_wins", 32'(v), 32'h3333);

    // reset mid-access
    req[0] = 1'b1;
    we[0] = 1'b1;
    addr[0 +: AW] = AW'(2);
    data[0 +: DW] = 16'h5555;
    step();
    step();
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_ack", 32'(ack), 32'd0);
    rst = 1'b1;
    req = '0;
    step();
    rst = 1'b0;
    check("post_rst_ack", 32'(ack), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    run_acc(0, 1'b0, 2, 16'h0, v, er, rc, lat);
    check("mid_rst_no_write", 32'(v), 32'h0000);

`ifdef ARB_MEM_CTRL_STATS_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    run_acc(0, 1'b1, 0, 16'hA5A5, v, er, rc, lat);
    run_acc(1, 1'b0, 7, 16'h0, v, er, rc, lat);
    run_acc(0, 1'b0, 0, 16'h0, v, er, rc, lat);
    run_acc(1, 1'b1, 9, 16'h7777, v, er, rc, lat);
    run_acc(0, 1'b0, 4, 16'h0, v, er, rc, lat);
    check("stats_access5", 32'(access_count), 32'd5);
    check("stats_error2", 32'(error_count), 32'd2);
    for (int i = 0; i < 300; i++) run_acc(1, 1'b0, 15, 16'h0, v, er, rc, lat);
    check("stats_error_sat", 32'(error_count), 32'hFF);
    check("stats_access305", 32'(access_count), 32'd305);
`endif

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (rst) req = '0;
      step();
      for (int c = 0; c < NCH; c++) begin
        if (rst || exp_ack[c]) continue;
        if (req[c] && m_inflight && m_g == c) begin
          // operands of the granted channel are latched; scrambling them is legal
          we[c] = 1'($urandom_range(0, 1));
          addr[c*AW +: AW] = AW'($urandom_range(0, 15));
          data[c*DW +: DW] = DW'($urandom);
        end else if (!req[c] && $urandom_range(0, 3) == 0) begin
          req[c] = 1'b1;
          we[c] = 1'($urandom_range(0, 1));
          addr[c*AW +: AW] = ($urandom_range(0, 9) == 0) ? AW'(15) : AW'($urandom_range(0, 6));
          data[c*DW +: DW] = DW'($urandom);
        end
      end
    end
    rst = 1'b0;
    req = '0;
    for (int i = 0; i < LAT + 3; i++) step();
    check("final_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end
endmodule
